alu_arbiter: RTL
================

# alu_arbiter

Shares the single `alu` instance between two requesters: the main pipeline on port 0 and the security/tag-check unit on port 1. Each port has a valid/ready request channel and a valid/ready response channel. The block arbitrates, drives the ALU operand, opcode and enable pins, and sequences multi-cycle operations via the ALU `busy` output. Completion detection is opcode-agnostic and works with either shifter build of the ALU.

## Interface
Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- OP_W, 5, ALU opcode width; encodings from `cpu/aludefs.vh`.

Ports:
- I_clk  in  1  clock.
- I_reset_n  in  1  one clock; reset is asynchronous and active-low.
- I_reqN_valid  in  1  port N (N=0,1) request valid.
- O_reqN_ready  out  1  port N request accepted this cycle.
- I_reqN_dataS1 / I_reqN_dataS2  in  DATA_W  port N operands.
- I_reqN_aluop  in  OP_W  port N opcode.
- O_rspN_valid  out  1  port N result valid.
- I_rspN_ready  in  1  port N consumes the result.
- O_rsp_data  out  DATA_W  result, shared by both ports.
- O_rsp_lt / O_rsp_ltu / O_rsp_eq  out  1  compare flags, shared.
- O_alu_en  out  1  to ALU I_en.
- O_alu_dataS1 / O_alu_dataS2  out  DATA_W  to ALU operands.
- O_alu_aluop  out  OP_W  to ALU opcode.
- I_alu_busy  in  1  from ALU O_busy.
- I_alu_data  in  DATA_W  from ALU O_data.
- I_alu_lt / I_alu_ltu / I_alu_eq  in  1  from ALU flags.

## Operation
- One operation is in flight at a time. The request is latched into `s1_q`, `s2_q`, `op_q` and `owner_q`. These registers feed the O_alu_* pins and stay stable until RESP completes.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to one valid port; O_reqN_ready=1 for the granted port only (combinational).
  - On grant: latch the request, then go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE: O_alu_en=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - O_alu_en = I_alu_busy. This must be combinational: the ALU restarts a shift if enabled while busy=0.
  - I_alu_busy=0 → go to RESP. The ALU result is final at this point.
- RESP:
  - O_rsp{owner_q}_valid=1; the other port's response valid stays 0.
  - O_rsp_* are driven straight from the I_alu_* inputs; the ALU holds its result because en=0.
  - On I_rsp{owner_q}_ready=1 → go to IDLE. The valid is held until this handshake.
- O_alu_en=0 in IDLE and RESP.
- O_reqN_ready=0 outside IDLE.
- Reset value of every output is 0. All latches reset to 0, state resets to IDLE and the arbitration pointer resets to port 0.
- An asynchronous reset mid-operation drops the operation silently. The top level resets the ALU (synchronous, active-high) from the same source, so the ALU busy flag clears as well.
- A requester may drop valid in any cycle it was not granted; this has no effect.

## Timing
- Request handshake in cycle T: ISSUE at T+1, WAIT at T+2.
- Single-cycle op (busy stays 0): RESP at T+3. Minimum throughput is one op per 4 cycles when the response is consumed immediately.
- Multi-cycle shift by n (0–31):
  - ALU loads at T+1 and busy=1 from T+2 through T+2+n.
  - en is asserted T+1..T+2+n.
  - busy=0 at T+3+n → RESP at T+4+n.
- Response backpressure: RESP persists indefinitely with stable data.
- A request arriving during RESP is accepted no earlier than the cycle after the response handshake, in IDLE.

## Configuration
- ALU_ARB_FAIR_EN defined (round-robin):
  - The pointer selects the preferred port when both ports are valid.
  - The pointer moves to the other port after each grant.
- ALU_ARB_FAIR_EN undefined (fixed priority):
  - Port 0 always wins when both ports are valid.
  - Port 1 is granted only when I_req0_valid=0.
  - No pointer register.

## Test plan
- Port 0 ADD 5+7, rsp ready held 1 → O_req0_ready at T, O_rsp0_valid at T+3 with data 12, O_rsp1_valid=0 throughout.
- Port 1 SLL 0x1 by 4 → O_alu_en high T+1..T+6, falls in the first cycle busy=0. RESP at T+8 with data 0x10, on port 1 only.
- Both ports valid continuously with ADD ops:
  - FAIR_EN defined: grants alternate 0,1,0,1.
  - FAIR_EN undefined: port 0 granted every time, port 1 never.
- Port 0 SUB 3-5 with I_rsp0_ready=0 for 10 cycles → valid and data 0xFFFFFFFE with lt=1, ltu=1 held stable. Port 1 request is not accepted until 1 cycle after the handshake.
- I_reset_n pulsed low during WAIT of SRA 0x80000000 by 31 → all outputs 0 immediately, state IDLE. The next ADD 1+1 on port 1 completes with 2 and no spurious response.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between the main pipeline (port 0) and the tag-check unit (port 1).
// Arbitration is fixed priority to port 0 unless ALU_ARB_FAIR_EN is defined (round-robin).
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              I_clk,
  input  logic              I_reset_n,
  // Request channel 0 (main pipeline)
  input  logic              I_req0_valid,
  output logic              O_req0_ready,
  input  logic [DATA_W-1:0] I_req0_dataS1,
  input  logic [DATA_W-1:0] I_req0_dataS2,
  input  logic [OP_W-1:0]   I_req0_aluop,
  // Request channel 1 (security/tag-check unit)
  input  logic              I_req1_valid,
  output logic              O_req1_ready,
  input  logic [DATA_W-1:0] I_req1_dataS1,
  input  logic [DATA_W-1:0] I_req1_dataS2,
  input  logic [OP_W-1:0]   I_req1_aluop,
  // Response channels, shared data/flags
  output logic              O_rsp0_valid,
  input  logic              I_rsp0_ready,
  output logic              O_rsp1_valid,
  input  logic              I_rsp1_ready,
  output logic [DATA_W-1:0] O_rsp_data,
  output logic              O_rsp_lt,
  output logic              O_rsp_ltu,
  output logic              O_rsp_eq,
  // ALU side
  output logic              O_alu_en,
  output logic [DATA_W-1:0] O_alu_dataS1,
  output logic [DATA_W-1:0] O_alu_dataS2,
  output logic [OP_W-1:0]   O_alu_aluop,
  input  logic              I_alu_busy,
  input  logic [DATA_W-1:0] I_alu_data,
  input  logic              I_alu_lt,
  input  logic              I_alu_ltu,
  input  logic              I_alu_eq,
  // Debug view of the sequencing FSM
  output logic [1:0]        O_dbg_state
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both 1 at the
  // rising edge; valid never waits on ready, and a held valid keeps its payload stable.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   s1_q, s2_q;
  logic [OP_W-1:0]     op_q;
  logic                owner_q;
  logic                grant0, grant1;
  logic                idle;

  assign idle = (state_q == S_IDLE);

`ifdef ALU_ARB_FAIR_EN
  logic ptr_q;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (idle) begin
      if (I_req0_valid && I_req1_valid) begin
        grant0 = ~ptr_q;
        grant1 = ptr_q;
      end else begin
        grant0 = I_req0_valid;
        grant1 = I_req1_valid;
      end
    end
  end

  // Pointer names the port preferred on the next contended grant.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      ptr_q <= 1'b0;
    end else if (grant0) begin
      ptr_q <= 1'b1;
    end else if (grant1) begin
      ptr_q <= 1'b0;
    end
  end
`else
  always_comb begin
    grant0 = idle & I_req0_valid;
    grant1 = idle & I_req1_valid & ~I_req0_valid;
  end
`endif

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      op_q    <= '0;
      owner_q <= 1'b0;
    end else if (grant0) begin
      s1_q    <= I_req0_dataS1;
      s2_q    <= I_req0_dataS2;
      op_q    <= I_req0_aluop;
      owner_q <= 1'b0;
    end else if (grant1) begin
      s1_q    <= I_req1_dataS1;
      s2_q    <= I_req1_dataS2;
      op_q    <= I_req1_aluop;
      owner_q <= 1'b1;
    end
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    O_alu_en     = 1'b0;
    O_rsp0_valid = 1'b0;
    O_rsp1_valid = 1'b0;
    O_rsp_data   = '0;
    O_rsp_lt     = 1'b0;
    O_rsp_ltu    = 1'b0;
    O_rsp_eq     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        O_alu_en = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // Enable must drop in the same cycle busy drops, or the ALU restarts the op.
        O_alu_en = I_alu_busy;
        if (!I_alu_busy) state_d = S_RESP;
      end
      S_RESP: begin
        O_rsp0_valid = ~owner_q;
        O_rsp1_valid = owner_q;
        O_rsp_data   = I_alu_data;
        O_rsp_lt     = I_alu_lt;
        O_rsp_ltu    = I_alu_ltu;
        O_rsp_eq     = I_alu_eq;
        if (owner_q ? I_rsp1_ready : I_rsp0_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign O_req0_ready = grant0;
  assign O_req1_ready = grant1;
  assign O_alu_dataS1 = s1_q;
  assign O_alu_dataS2 = s2_q;
  assign O_alu_aluop  = op_q;
  assign O_dbg_state  = state_q;

endmodule
